// File: rtl/id_stage_pkg.sv
// id_stage_pkg: bus widths, ds_to_es_bus field offsets, alu_op bit indices and decode types.
// Revision: 1.0
`default_nettype none

package id_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int BR_BUS_WD       = 34;
  localparam int DS_TO_ES_BUS_WD = 150;
  localparam int FWD_BUS_WD      = 40;

  // LSB positions of the ds_to_es_bus fields
  localparam int DS_PC_LSB       = 0;
  localparam int DS_RKD_LSB      = 32;
  localparam int DS_RJ_LSB       = 64;
  localparam int DS_IMM_LSB      = 96;
  localparam int DS_DEST_LSB     = 128;
  localparam int DS_GR_WE_BIT    = 133;
  localparam int DS_SRC2_IMM_BIT = 134;
  localparam int DS_SRC1_PC_BIT  = 135;
  localparam int DS_MEM_WE_BIT   = 136;
  localparam int DS_LOAD_OP_BIT  = 137;
  localparam int DS_ALU_OP_LSB   = 138;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef struct packed {
    logic        valid;
    logic        gr_we;
    logic        is_load;
    logic [4:0]  dest;
    logic [31:0] result;
  } fwd_t;

  typedef struct packed {
    logic [11:0] alu_op;
    logic        load_op;
    logic        mem_we;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [4:0]  rj;
    logic [4:0]  rkd;
    logic        use_rj;
    logic        use_rkd;
    logic        is_jump;
    logic        is_jirl;
    logic        is_beq;
    logic        is_bne;
    logic [31:0] br_offs;
  } dec_t;

  function automatic logic fwd_hit(input logic valid, input logic gr_we,
                                   input logic [4:0] dest, input logic [4:0] src);
    return valid && gr_we && (dest != 5'd0) && (dest == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_decoder.sv
// id_decoder: combinational LA32R subset decode of one instruction word.
// Revision: 1.0
`default_nettype none

module id_decoder
  import id_stage_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [16:0] op17;
  logic [9:0]  op10;
  logic [6:0]  op7;
  logic [5:0]  op6;
  assign op17 = inst[31:15];
  assign op10 = inst[31:22];
  assign op7  = inst[31:25];
  assign op6  = inst[31:26];

  logic is_add, is_sub, is_slt, is_sltu, is_and, is_or, is_nor, is_xor;
  logic is_slli, is_srli, is_srai, is_addi, is_lu12i, is_ld, is_st;
  logic is_jirl, is_b, is_bl, is_beq, is_bne, is_3r, is_shift;

  assign is_add   = (op17 == 17'h00020);
  assign is_sub   = (op17 == 17'h00022);
  assign is_slt   = (op17 == 17'h00024);
  assign is_sltu  = (op17 == 17'h00025);
  assign is_nor   = (op17 == 17'h00028);
  assign is_and   = (op17 == 17'h00029);
  assign is_or    = (op17 == 17'h0002a);
  assign is_xor   = (op17 == 17'h0002b);
  assign is_slli  = (op17 == 17'h00081);
  assign is_srli  = (op17 == 17'h00089);
  assign is_srai  = (op17 == 17'h00091);
  assign is_addi  = (op10 == 10'h00a);
  assign is_ld    = (op10 == 10'h0a2);
  assign is_st    = (op10 == 10'h0a6);
  assign is_lu12i = (op7  == 7'b0001010);
  assign is_jirl  = (op6  == 6'b010011);
  assign is_b     = (op6  == 6'b010100);
  assign is_bl    = (op6  == 6'b010101);
  assign is_beq   = (op6  == 6'b010110);
  assign is_bne   = (op6  == 6'b010111);

  assign is_3r    = is_add | is_sub | is_slt | is_sltu | is_and | is_or | is_nor | is_xor;
  assign is_shift = is_slli | is_srli | is_srai;

  always_comb begin
    dec = '0;
    dec.alu_op[ALU_ADD]  = is_add | is_addi | is_ld | is_st | is_jirl | is_bl;
    dec.alu_op[ALU_SUB]  = is_sub;
    dec.alu_op[ALU_SLT]  = is_slt;
    dec.alu_op[ALU_SLTU] = is_sltu;
    dec.alu_op[ALU_AND]  = is_and;
    dec.alu_op[ALU_NOR]  = is_nor;
    dec.alu_op[ALU_OR]   = is_or;
    dec.alu_op[ALU_XOR]  = is_xor;
    dec.alu_op[ALU_SLL]  = is_slli;
    dec.alu_op[ALU_SRL]  = is_srli;
    dec.alu_op[ALU_SRA]  = is_srai;
    dec.alu_op[ALU_LUI]  = is_lu12i;

    dec.load_op     = is_ld;
    dec.mem_we      = is_st;
    dec.src1_is_pc  = is_bl | is_jirl;
    dec.src2_is_imm = is_addi | is_shift | is_lu12i | is_ld | is_st | is_bl | is_jirl;
    dec.gr_we       = is_3r | is_shift | is_addi | is_lu12i | is_ld | is_jirl | is_bl;

    if (!dec.gr_we)  dec.dest = 5'd0;
    else if (is_bl)  dec.dest = 5'd1;
    else             dec.dest = inst[4:0];

    if (is_addi | is_ld | is_st)  dec.imm = {{20{inst[21]}}, inst[21:10]};
    else if (is_shift)            dec.imm = {27'd0, inst[14:10]};
    else if (is_lu12i)            dec.imm = {inst[24:5], 12'd0};
    else if (is_bl | is_jirl)     dec.imm = 32'd4;

    // lu12i.w reads r0 so it can never create a false forwarding/stall dependency
    dec.rj      = is_lu12i ? 5'd0 : inst[9:5];
    dec.rkd     = (is_st | is_beq | is_bne) ? inst[4:0] : inst[14:10];
    dec.use_rj  = is_3r | is_shift | is_addi | is_ld | is_st | is_jirl | is_beq | is_bne;
    dec.use_rkd = is_3r | is_st | is_beq | is_bne;

    dec.is_jump = is_b | is_bl;
    dec.is_jirl = is_jirl;
    dec.is_beq  = is_beq;
    dec.is_bne  = is_bne;
    dec.br_offs = (is_b | is_bl) ? {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00}
                                 : {{14{inst[25]}}, inst[25:10], 2'b00};
  end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// id_stage: LA32R decode stage with forwarding, load-use stall and branch resolution.
// Define DS_PERF_CNT_EN to add the ds_stall_cnt / ds_issue_cnt counters. Revision: 1.0
`default_nettype none

module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC_UNUSED = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_allowin,
  output logic                       ds_allowin,
  input  logic                       fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       ds_to_es_valid,
  output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic [BR_BUS_WD-1:0]       br_bus,
  output logic [4:0]                 rf_raddr1,
  output logic [4:0]                 rf_raddr2,
  input  logic [31:0]                rf_rdata1,
  input  logic [31:0]                rf_rdata2,
  input  logic [FWD_BUS_WD-1:0]      es_fwd_bus,
  input  logic [FWD_BUS_WD-1:0]      ms_fwd_bus,
  input  logic [FWD_BUS_WD-1:0]      ws_fwd_bus,
  input  logic                       ds_flush_pipe
`ifdef DS_PERF_CNT_EN
  ,
  output logic [31:0]                ds_stall_cnt,
  output logic [31:0]                ds_issue_cnt
`endif
);

  logic                       ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] ds_bus_r;
  logic [31:0]                inst;
  logic [31:0]                pc;
  dec_t                       dec;
  fwd_t                       es, ms, ws;
  logic [31:0]                rj_val, rkd_val, br_target;
  logic                       load_use_stall, ds_ready_go, br_cond, br_taken;
  logic [33:0]                unused_ok;

  assign inst = ds_bus_r[63:32];
  assign pc   = ds_bus_r[31:0];
  assign es   = es_fwd_bus;
  assign ms   = ms_fwd_bus;
  assign ws   = ws_fwd_bus;
  assign unused_ok = {ms.is_load, ws.is_load, RESET_PC_UNUSED};

  id_decoder u_decoder (
    .inst (inst),
    .dec  (dec)
  );

  assign rf_raddr1 = dec.rj;
  assign rf_raddr2 = dec.rkd;

  always_comb begin
    rj_val = rf_rdata1;
    if (dec.rj == 5'd0)                                       rj_val = 32'd0;
    else if (fwd_hit(es.valid, es.gr_we, es.dest, dec.rj))    rj_val = es.result;
    else if (fwd_hit(ms.valid, ms.gr_we, ms.dest, dec.rj))    rj_val = ms.result;
    else if (fwd_hit(ws.valid, ws.gr_we, ws.dest, dec.rj))    rj_val = ws.result;

    rkd_val = rf_rdata2;
    if (dec.rkd == 5'd0)                                      rkd_val = 32'd0;
    else if (fwd_hit(es.valid, es.gr_we, es.dest, dec.rkd))   rkd_val = es.result;
    else if (fwd_hit(ms.valid, ms.gr_we, ms.dest, dec.rkd))   rkd_val = ms.result;
    else if (fwd_hit(ws.valid, ws.gr_we, ws.dest, dec.rkd))   rkd_val = ws.result;
  end

  assign load_use_stall = es.valid && es.is_load && (es.dest != 5'd0) &&
                          ((dec.use_rj  && (es.dest == dec.rj)) ||
                           (dec.use_rkd && (es.dest == dec.rkd)));
  assign ds_ready_go    = !load_use_stall;
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go && !ds_flush_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid <= 1'b0;
      ds_bus_r <= '0;
    end else if (ds_flush_pipe) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid) ds_bus_r <= fs_to_ds_bus;
    end
  end

  assign br_cond   = (dec.is_beq && (rj_val == rkd_val)) || (dec.is_bne && (rj_val != rkd_val));
  assign br_target = dec.is_jirl ? (rj_val + dec.br_offs) : (pc + dec.br_offs);
  // Gating with es_allowin makes the redirect a single pulse even if the branch waits in decode
  assign br_taken  = ds_valid && ds_ready_go && es_allowin && !ds_flush_pipe &&
                     (dec.is_jump || dec.is_jirl || br_cond);
  assign br_bus    = {br_taken, br_taken, br_taken ? br_target : 32'd0};

  assign ds_to_es_bus[DS_ALU_OP_LSB +: 12] = dec.alu_op;
  assign ds_to_es_bus[DS_LOAD_OP_BIT]      = dec.load_op;
  assign ds_to_es_bus[DS_MEM_WE_BIT]       = dec.mem_we;
  assign ds_to_es_bus[DS_SRC1_PC_BIT]      = dec.src1_is_pc;
  assign ds_to_es_bus[DS_SRC2_IMM_BIT]     = dec.src2_is_imm;
  assign ds_to_es_bus[DS_GR_WE_BIT]        = dec.gr_we;
  assign ds_to_es_bus[DS_DEST_LSB +: 5]    = dec.dest;
  assign ds_to_es_bus[DS_IMM_LSB +: 32]    = dec.imm;
  assign ds_to_es_bus[DS_RJ_LSB +: 32]     = dec.src1_is_pc ? pc : rj_val;
  assign ds_to_es_bus[DS_RKD_LSB +: 32]    = rkd_val;
  assign ds_to_es_bus[DS_PC_LSB +: 32]     = pc;

`ifdef DS_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_stall_cnt <= 32'd0;
      ds_issue_cnt <= 32'd0;
    end else begin
      if (ds_valid && !ds_ready_go)       ds_stall_cnt <= ds_stall_cnt + 32'd1;
      if (ds_to_es_valid && es_allowin)   ds_issue_cnt <= ds_issue_cnt + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector self-checking bench for id_stage.
// Revision: 1.0
`default_nettype none

module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_allowin;
  logic         ds_allowin;
  logic         fs_to_ds_valid;
  logic [63:0]  fs_to_ds_bus;
  logic         ds_to_es_valid;
  logic [149:0] ds_to_es_bus;
  logic [33:0]  br_bus;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic [39:0]  es_fwd_bus, ms_fwd_bus, ws_fwd_bus;
  logic         ds_flush_pipe;
`ifdef DS_PERF_CNT_EN
  logic [31:0]  ds_stall_cnt, ds_issue_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // register file stub: rN reads 0x1000+N, including r0 (which the DUT must override to 0)
  assign rf_rdata1 = 32'h1000 + {27'd0, rf_raddr1};
  assign rf_rdata2 = 32'h1000 + {27'd0, rf_raddr2};

  id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .es_allowin     (es_allowin),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .br_bus         (br_bus),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .es_fwd_bus     (es_fwd_bus),
    .ms_fwd_bus     (ms_fwd_bus),
    .ws_fwd_bus     (ws_fwd_bus),
    .ds_flush_pipe  (ds_flush_pipe)
`ifdef DS_PERF_CNT_EN
    ,
    .ds_stall_cnt   (ds_stall_cnt),
    .ds_issue_cnt   (ds_issue_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, rj, input logic [11:0] si12);
    return {10'h00a, si12, rj, rd};
  endfunction
  function automatic logic [31:0] enc_add(input logic [4:0] rd, rj, rk);
    return {17'h00020, rk, rj, rd};
  endfunction
  function automatic logic [31:0] enc_st(input logic [4:0] rd, rj, input logic [11:0] si12);
    return {10'h0a6, si12, rj, rd};
  endfunction
  function automatic logic [31:0] enc_lu12i(input logic [4:0] rd, input logic [19:0] si20);
    return {7'b0001010, si20, rd};
  endfunction
  function automatic logic [31:0] enc_beq(input logic [4:0] rj, rd, input logic [15:0] offs);
    return {6'b010110, offs, rj, rd};
  endfunction
  function automatic logic [31:0] enc_b26(input logic [5:0] op, input logic [25:0] offs);
    return {op, offs[15:0], offs[25:16]};
  endfunction
  function automatic logic [39:0] fwd(input logic v, we, ld, input logic [4:0] d, input logic [31:0] r);
    return {v, we, ld, d, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] inst, input logic [31:0] pc);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {inst, pc};
    tick();
    fs_to_ds_valid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; es_allowin = 1'b1; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0;
    es_fwd_bus = '0; ms_fwd_bus = '0; ws_fwd_bus = '0; ds_flush_pipe = 1'b0;
    tick(); tick();
    check("rst_valid",   {63'd0, ds_to_es_valid}, 64'd0);
    check("rst_br_bus",  {30'd0, br_bus}, 64'd0);
    check("rst_allowin", {63'd0, ds_allowin}, 64'd1);

    // addi.w r2,r0,5
    reset = 1'b0;
    load(enc_addi(5'd2, 5'd0, 12'd5), 32'h1c000000);
    check("addi_valid", {63'd0, ds_to_es_valid}, 64'd1);
    check("addi_dest",  {59'd0, ds_to_es_bus[132:128]}, 64'd2);
    check("addi_imm",   {32'd0, ds_to_es_bus[127:96]}, 64'd5);
    check("addi_rj",    {32'd0, ds_to_es_bus[95:64]}, 64'd0);
    check("addi_aluop", {52'd0, ds_to_es_bus[149:138]}, 64'h001);
    check("addi_pc",    {32'd0, ds_to_es_bus[31:0]}, 64'h1c000000);

    // add.w r3,r2,r2 with forwarding priority es > ms > ws > rf
    es_fwd_bus = fwd(1'b1, 1'b1, 1'b0, 5'd2, 32'h11);
    ms_fwd_bus = fwd(1'b1, 1'b1, 1'b0, 5'd2, 32'h22);
    load(enc_add(5'd3, 5'd2, 5'd2), 32'h1c000004);
    es_allowin = 1'b0;
    #1;
    check("fwd_es_rj",  {32'd0, ds_to_es_bus[95:64]}, 64'h11);
    check("fwd_es_rkd", {32'd0, ds_to_es_bus[63:32]}, 64'h11);
    check("add_dest",   {59'd0, ds_to_es_bus[132:128]}, 64'd3);
    es_fwd_bus = '0;
    #1;
    check("fwd_ms_rj",  {32'd0, ds_to_es_bus[95:64]}, 64'h22);
    ms_fwd_bus = '0;
    ws_fwd_bus = fwd(1'b1, 1'b1, 1'b0, 5'd2, 32'h33);
    #1;
    check("fwd_ws_rkd", {32'd0, ds_to_es_bus[63:32]}, 64'h33);
    ws_fwd_bus = fwd(1'b1, 1'b0, 1'b0, 5'd2, 32'h44);
    #1;
    check("fwd_rf_rj",  {32'd0, ds_to_es_bus[95:64]}, 64'h1002);
    ws_fwd_bus = '0;
    es_allowin = 1'b1;
    tick();

    // load-use: beq r4,r5 behind a load to r4
    es_fwd_bus = fwd(1'b1, 1'b1, 1'b1, 5'd4, 32'hdead);
    load(enc_beq(5'd4, 5'd5, 16'd3), 32'h1c000008);
    check("lu_allowin", {63'd0, ds_allowin}, 64'd0);
    check("lu_valid",   {63'd0, ds_to_es_valid}, 64'd0);
    check("lu_br",      {63'd0, br_bus[33]}, 64'd0);
    tick();
    es_fwd_bus = '0;
    ms_fwd_bus = fwd(1'b1, 1'b1, 1'b1, 5'd4, 32'h1005);
    #1;
    check("lu_go_valid", {63'd0, ds_to_es_valid}, 64'd1);
    check("lu_go_rj",    {32'd0, ds_to_es_bus[95:64]}, 64'h1005);
    check("lu_go_br",    {30'd0, br_bus}, {30'd0, 2'b11, 32'h1c000014});
    tick();
    ms_fwd_bus = '0;
    check("lu_br_drop",  {63'd0, br_bus[33]}, 64'd0);

    // beq r1,r1 taken, one-cycle pulse
    load(enc_beq(5'd1, 5'd1, 16'd4), 32'h1c000010);
    check("beq_br", {30'd0, br_bus}, {30'd0, 2'b11, 32'h1c000020});
    tick();
    check("beq_pulse", {30'd0, br_bus}, 64'd0);

    // b with negative offset
    load(enc_b26(6'b010100, 26'h3fffffe), 32'h1c000030);
    check("b_neg", {30'd0, br_bus}, {30'd0, 2'b11, 32'h1c000028});
    tick();

    // st.w r7,r8,16: rkd is rd, no register write
    load(enc_st(5'd7, 5'd8, 12'd16), 32'h1c000034);
    check("st_raddr2", {59'd0, rf_raddr2}, 64'd7);
    check("st_rkd",    {32'd0, ds_to_es_bus[63:32]}, 64'h1007);
    check("st_ctl",    {59'd0, ds_to_es_bus[137:133]}, 64'b01010);
    check("st_dest",   {59'd0, ds_to_es_bus[132:128]}, 64'd0);
    tick();

    // lu12i.w r6,0x12345
    load(enc_lu12i(5'd6, 20'h12345), 32'h1c000038);
    check("lui_imm",   {32'd0, ds_to_es_bus[127:96]}, 64'h12345000);
    check("lui_rj",    {32'd0, ds_to_es_bus[95:64]}, 64'd0);
    check("lui_aluop", {52'd0, ds_to_es_bus[149:138]}, 64'h800);
    tick();

    // unknown encoding becomes a bubble
    load(32'hffffffff, 32'h1c00003c);
    check("bub_valid", {63'd0, ds_to_es_valid}, 64'd1);
    check("bub_ctl",   {59'd0, ds_to_es_bus[137:133]}, 64'd0);
    check("bub_dest",  {59'd0, ds_to_es_bus[132:128]}, 64'd0);
    check("bub_br",    {30'd0, br_bus}, 64'd0);
    tick();

    // bl held by es_allowin=0 for 3 cycles
    es_allowin = 1'b0;
    load(enc_b26(6'b010101, 26'h10), 32'h1c000040);
    for (int i = 0; i < 3; i++) begin
      check("bl_hold_br",    {63'd0, br_bus[33]}, 64'd0);
      check("bl_hold_valid", {63'd0, ds_to_es_valid}, 64'd1);
      tick();
    end
    es_allowin = 1'b1;
    #1;
    check("bl_br",   {30'd0, br_bus}, {30'd0, 2'b11, 32'h1c000080});
    check("bl_dest", {59'd0, ds_to_es_bus[132:128]}, 64'd1);
    check("bl_rj",   {32'd0, ds_to_es_bus[95:64]}, 64'h1c000040);
    check("bl_imm",  {32'd0, ds_to_es_bus[127:96]}, 64'd4);
    check("bl_src",  {62'd0, ds_to_es_bus[135:134]}, 64'b11);
    tick();
    check("bl_pulse", {63'd0, br_bus[33]}, 64'd0);

    // flush with a taken branch in decode and a new fetch arriving
    load(enc_beq(5'd1, 5'd1, 16'd4), 32'h1c000050);
    ds_flush_pipe  = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {enc_add(5'd3, 5'd1, 5'd1), 32'h1c000054};
    #1;
    check("fl_valid", {63'd0, ds_to_es_valid}, 64'd0);
    check("fl_br",    {30'd0, br_bus}, 64'd0);
    tick();
    ds_flush_pipe  = 1'b0;
    fs_to_ds_valid = 1'b0;
    #1;
    check("fl_after_valid",   {63'd0, ds_to_es_valid}, 64'd0);
    check("fl_after_allowin", {63'd0, ds_allowin}, 64'd1);

    // asynchronous reset during a load-use stall
    es_fwd_bus = fwd(1'b1, 1'b1, 1'b1, 5'd4, 32'hbeef);
    load(enc_add(5'd9, 5'd4, 5'd0), 32'h1c000060);
    check("rs_stall", {63'd0, ds_allowin}, 64'd0);
    #1 reset = 1'b1;
    #1;
    check("rs_allowin", {63'd0, ds_allowin}, 64'd1);
    reset = 1'b0;
    es_fwd_bus = '0;
    #1;
    check("rs_dropped", {63'd0, ds_to_es_valid}, 64'd0);
    tick();
    check("rs_still_empty", {63'd0, ds_to_es_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage directly downstream of the fetch stage.
- Holds one instruction in a pipeline register and decodes a fixed LA32R integer subset.
- Reads the register file and forwards operands from the EX, MEM and WB stages.
- Detects load-use hazards, resolves branches and jumps, and redirects fetch through br_bus. Packs decoded fields into ds_to_es_bus for the execute stage.

Parameters:
- RESET_PC_UNUSED, 0: none functional. Widths come from shared header constants: FS_TO_DS_BUS_WD=64, BR_BUS_WD=34, DS_TO_ES_BUS_WD=150, FWD_BUS_WD=40.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- es_allowin  in  1  execute stage can accept
- ds_allowin  out  1  decode can accept from fetch
- fs_to_ds_valid  in  1  fetch output valid
- fs_to_ds_bus  in  64  {inst[31:0], pc[31:0]}
- ds_to_es_valid  out  1  decode output valid
- ds_to_es_bus  out  150  {alu_op[11:0], load_op, mem_we, src1_is_pc, src2_is_imm, gr_we, dest[4:0], imm[31:0], rj_value[31:0], rkd_value[31:0], pc[31:0]}
- br_bus  out  34  {br_taken, br_taken_cancel, br_target[31:0]}
- rf_raddr1, rf_raddr2  out  5  register file read addresses
- rf_rdata1, rf_rdata2  in  32  register file read data (combinational)
- es_fwd_bus  in  40  {valid, gr_we, is_load, dest[4:0], result[31:0]}
- ms_fwd_bus, ws_fwd_bus  in  40  same layout; is_load is ignored
- ds_flush_pipe  in  1  exception/ertn flush from writeback

Behaviour:
- Register ds_valid and ds_bus_r[63:0]. On reset: ds_valid=0, ds_bus_r=0, so ds_to_es_valid=0 and br_bus=0.
- Capture: if ds_flush_pipe, then ds_valid<=0. Else if ds_allowin, then ds_valid<=fs_to_ds_valid, and ds_bus_r<=fs_to_ds_bus when fs_to_ds_valid. Flush has priority over capture in the same cycle.
- ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
- ds_ready_go = !load_use_stall.
- ds_to_es_valid = ds_valid && ds_ready_go && !ds_flush_pipe.
- Decode subset: add.w, sub.w, slt, sltu, and, or, nor, xor, slli.w, srli.w, srai.w, addi.w, lu12i.w, ld.w, st.w, jirl, b, bl, beq, bne.
- Any other encoding decodes as a bubble: gr_we=0, mem_we=0, load_op=0, no branch. It still passes through the pipe.
- Source registers:
  - rj is inst[9:5].
  - rkd is inst[14:10]; for st.w, beq and bne it is rd, inst[4:0].
  - bl writes r1. All other writers write rd.
  - dest is forced to 0 when gr_we=0.
- Forwarding per operand, priority es > ms > ws > rf. A match requires stage valid && gr_we && dest!=0 && dest==src. Reads of r0 always yield 0.
- load_use_stall: es valid && es is_load && es dest!=0 && es dest equals a source actually used by the instruction.
- Branch: br_cond is evaluated on forwarded operands.
  - br_taken = ds_valid && ds_ready_go && es_allowin && !ds_flush_pipe && (jump || br_cond). It is a one-cycle pulse per instruction.
  - br_taken_cancel = br_taken.
- Branch targets:
  - b, bl, beq, bne: pc + sext(offs<<2).
  - jirl: rj + sext(offs16<<2).
  - bl and jirl write pc+4. The link value is carried as rj_value=pc and imm=4 with src1_is_pc and src2_is_imm set.
- Immediates: si12 sign-extended; ui5 zero-extended; lu12i.w uses {si20,12'b0} with rj forced to r0. All arithmetic is 32-bit, wrapping.
- Reset asserted mid-stall drops the held instruction immediately.

Optional Feature:
- Macro DS_PERF_CNT_EN.
- With it: adds outputs ds_stall_cnt[31:0] and ds_issue_cnt[31:0], both reset to 0, both wrapping.
  - ds_stall_cnt increments on each ds_valid && !ds_ready_go cycle.
  - ds_issue_cnt increments on each ds_to_es_valid && es_allowin cycle.
- Without it: the ports and counters are absent.

Decomposition:
- mycpu.h holds the bus widths, the field offsets of ds_to_es_bus, and the alu_op bit indices (0 add … 11 lui).
- One combinational sub-module, id_decoder: inst → control fields, immediate, and source-use flags.
- Forwarding muxes, stall logic and branch logic stay in id_stage.

Test Plan:
- Reset held, then released with fs_to_ds_valid=1, inst=addi.w r2,r0,5, pc=0x1c000000 → next cycle ds_to_es_valid=1, dest=2, imm=5, rj_value=0.
- es_fwd_bus={1,1,0,2,0x11} and inst add.w r3,r2,r2 → rj_value=rkd_value=0x11; the rf values are ignored.
- es_fwd_bus={1,1,1,4,x} and inst beq r4,r5 → ds_allowin=0 and ds_to_es_valid=0 for 1 cycle. After the load leaves, forward from ms.
- beq r1,r1 at pc 0x1c000010 with offs16=4 → br_bus={1,1,0x1c000020} for exactly one cycle, with es_allowin=1.
- es_allowin=0 for 3 cycles while holding bl → br_taken stays 0, then pulses once when es_allowin rises; dest=1, rj_value=pc, imm=4.
- ds_flush_pipe=1 concurrent with fs_to_ds_valid=1 → ds_valid=0 next cycle, ds_to_es_valid=0, br_taken=0.
